// File: rtl/cmd_arbiter_pkg.sv
// Package usertype: bank command encoding and default DRAM timing constants.
// Address geometry comes from the global ADDR_BITS / BA_BITS macros; the
// guarded fallbacks keep this file usable regardless of compile order.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif

package usertype;

  localparam int unsigned ADDR_BITS = `ADDR_BITS;
  localparam int unsigned BA_BITS   = `BA_BITS;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } bank_cmd_t;

  localparam int unsigned NUM_BANKS_DEF = 8;
  localparam int unsigned T_RCD_DEF     = 4;
  localparam int unsigned T_RP_DEF      = 4;
  localparam int unsigned T_CCD_DEF     = 2;

endpackage

// File: rtl/cmd_arbiter_rr.sv
// rr_arbiter: purely combinational round-robin picker. The first requester
// found at or after ptr (wrapping) receives a one-hot grant.
module rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  // Scan from the pointer position, wrapping, and grant the first requester.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/define.sv
// Global address geometry shared by the command arbiter slice.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: grants the shared DRAM command bus to one bank FSM per cycle,
// enforcing tRCD/tRP per bank and tCCD across banks, with a registered
// command bus. Optional macro READ_PRIORITY_EN lets eligible reads win over
// all other eligible command classes.
module cmd_arbiter
  import usertype::*;
#(
  parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
  parameter int unsigned T_RCD     = T_RCD_DEF,
  parameter int unsigned T_RP      = T_RP_DEF,
  parameter int unsigned T_CCD     = T_CCD_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BANKS-1:0]           req,
  input  logic [2*NUM_BANKS-1:0]         req_cmd,
  input  logic [ADDR_BITS*NUM_BANKS-1:0] req_addr,
  output logic [NUM_BANKS-1:0]           stall,
  output logic [NUM_BANKS-1:0]           grant,
  output logic                           cmd_valid,
  output logic [1:0]                     cmd_type,
  output logic [BA_BITS-1:0]             cmd_bank,
  output logic [ADDR_BITS-1:0]           cmd_addr
);

  localparam int unsigned PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0]     trcd [NUM_BANKS];
  logic [CNT_W-1:0]     trp  [NUM_BANKS];
  logic [CNT_W-1:0]     tccd;
  logic [PTR_W-1:0]     ptr;

  logic [NUM_BANKS-1:0] elig;
  logic [NUM_BANKS-1:0] arb_req;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 gnt_any;
  bank_cmd_t            gnt_cmd;
  logic [ADDR_BITS-1:0] gnt_addr;

  // Per-bank eligibility from the request type and its timing counters.
  always_comb begin
    bank_cmd_t c;
    c    = CMD_ACT;
    elig = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      c = bank_cmd_t'(req_cmd[2*i +: 2]);
      if (req[i]) begin
        unique case (c)
          CMD_ACT:        elig[i] = (trp[i] == '0);
          CMD_RD, CMD_WR: elig[i] = (trcd[i] == '0) && (tccd == '0);
          CMD_PRE:        elig[i] = 1'b1;
          default:        elig[i] = 1'b0;
        endcase
      end
    end
  end

`ifdef READ_PRIORITY_EN
  logic [NUM_BANKS-1:0] rd_elig;

  // Narrow arbitration to eligible reads whenever any exist.
  always_comb begin
    rd_elig = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      rd_elig[i] = elig[i] && (bank_cmd_t'(req_cmd[2*i +: 2]) == CMD_RD);
    end
    arb_req = (|rd_elig) ? rd_elig : elig;
  end
`else
  // All eligible requests compete in plain round-robin.
  always_comb begin
    arb_req = elig;
  end
`endif

  rr_arbiter #(
    .N     (NUM_BANKS),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (grant)
  );

  // Decode the one-hot grant into the winning bank and its request slices.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
    gnt_any  = |grant;
    gnt_cmd  = bank_cmd_t'(req_cmd[2*gnt_idx +: 2]);
    gnt_addr = req_addr[ADDR_BITS*gnt_idx +: ADDR_BITS];
    stall    = req & ~grant;
  end

  // Timing counters and round-robin pointer; a load overrides the decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      tccd <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        trcd[i] <= '0;
        trp[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        if (grant[i] && gnt_cmd == CMD_ACT) trcd[i] <= CNT_W'(T_RCD - 1);
        else if (trcd[i] != '0)              trcd[i] <= trcd[i] - 1'b1;
        if (grant[i] && gnt_cmd == CMD_PRE) trp[i] <= CNT_W'(T_RP - 1);
        else if (trp[i] != '0)               trp[i] <= trp[i] - 1'b1;
      end
      if (gnt_any && (gnt_cmd == CMD_RD || gnt_cmd == CMD_WR)) tccd <= CNT_W'(T_CCD - 1);
      else if (tccd != '0)                                      tccd <= tccd - 1'b1;
      if (gnt_any) begin
        ptr <= (gnt_idx == PTR_W'(NUM_BANKS - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end
  end

  // Registered command bus: one cycle after the grant, zeroed when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_type  <= '0;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
    end else if (gnt_any) begin
      cmd_valid <= 1'b1;
      cmd_type  <= gnt_cmd;
      cmd_bank  <= BA_BITS'(gnt_idx);
      cmd_addr  <= gnt_addr;
    end else begin
      cmd_valid <= 1'b0;
      cmd_type  <= '0;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Testbench for cmd_arbiter: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model.
module tb_cmd_arbiter;
  import usertype::*;

  localparam int NB = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NB-1:0]           req;
  logic [2*NB-1:0]         req_cmd;
  logic [ADDR_BITS*NB-1:0] req_addr;
  logic [NB-1:0]           stall, grant;
  logic                    cmd_valid;
  logic [1:0]              cmd_type;
  logic [BA_BITS-1:0]      cmd_bank;
  logic [ADDR_BITS-1:0]    cmd_addr;

  int errors = 0;
  int checks = 0;

  // Reference model: earliest cycle at which each constraint allows a command.
  int cyc;
  int act_ok [NB];
  int rd_ok  [NB];
  int ccd_ok;
  int mptr;
  logic [NB-1:0]        exp_grant;
  logic                 exp_valid;
  logic [1:0]           exp_type;
  int                   exp_bank;
  logic [ADDR_BITS-1:0] exp_addr;

  cmd_arbiter #(.NUM_BANKS(8), .T_RCD(4), .T_RP(4), .T_CCD(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .stall(stall), .grant(grant), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    logic [NB-1:0] e, rdv;
    logic [1:0] c;
    int b;
    e = '0; rdv = '0;
    for (int i = 0; i < NB; i++) begin
      c = req_cmd[2*i +: 2];
      if (req[i]) begin
        if (c == CMD_ACT)      e[i] = (cyc >= act_ok[i]);
        else if (c == CMD_PRE) e[i] = 1'b1;
        else                   e[i] = (cyc >= rd_ok[i]) && (cyc >= ccd_ok);
        if (c == CMD_RD) rdv[i] = e[i];
      end
    end
`ifdef READ_PRIORITY_EN
    if (rdv != '0) e = rdv;
`endif
    exp_grant = '0;
    for (int off = 0; off < NB; off++) begin
      b = (mptr + off) % NB;
      if (e[b]) begin
        exp_grant[b] = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_update();
    logic [1:0] c;
    int b;
    b = 0;
    for (int i = 0; i < NB; i++) if (exp_grant[i]) b = i;
    c = req_cmd[2*b +: 2];
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin act_ok[i] = 0; rd_ok[i] = 0; end
      ccd_ok = 0; mptr = 0;
      exp_valid = 1'b0; exp_type = '0; exp_bank = 0; exp_addr = '0;
    end else if (exp_grant != '0) begin
      exp_valid = 1'b1; exp_type = c; exp_bank = b;
      exp_addr  = req_addr[b*ADDR_BITS +: ADDR_BITS];
      if (c == CMD_ACT)      rd_ok[b]  = cyc + 4;
      else if (c == CMD_PRE) act_ok[b] = cyc + 4;
      else                   ccd_ok    = cyc + 2;
      mptr = (b + 1) % NB;
    end else begin
      exp_valid = 1'b0; exp_type = '0; exp_bank = 0; exp_addr = '0;
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_eval();
    model_update();
    #1;
  endtask

  task automatic set_bank(input int b, input logic [1:0] c, input logic [ADDR_BITS-1:0] a);
    req[b] = 1'b1;
    req_cmd[2*b +: 2] = c;
    req_addr[b*ADDR_BITS +: ADDR_BITS] = a;
  endtask

  task automatic clear_req();
    req = '0; req_cmd = '0; req_addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_req();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    advance(); advance();
    settle();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", cmd_valid); end
    checks++; if (cmd_type !== 2'd0 || cmd_bank !== '0 || cmd_addr !== '0) begin
      errors++; $display("FAIL reset_bus got type=%0d bank=%0d addr=%0h exp=0", cmd_type, cmd_bank, cmd_addr); end
    checks++; if (grant !== 8'h00 || stall !== 8'h00) begin
      errors++; $display("FAIL reset_idle got grant=%h stall=%h exp=00/00", grant, stall); end
    set_bank(0, CMD_ACT, 14'h11);
    set_bank(7, CMD_ACT, 14'h77);
    settle();
    checks++; if (grant !== 8'h01 || stall !== 8'h80) begin
      errors++; $display("FAIL reset_comb_grant got grant=%h stall=%h exp=01/80", grant, stall); end
    advance();
    settle();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_no_cmd got=%0b exp=0", cmd_valid); end
    rst_n = 1'b1;
    clear_req();
    advance();
  endtask

  task automatic test_rr_act();
    do_reset();
    set_bank(0, CMD_ACT, 14'h0AA);
    set_bank(2, CMD_ACT, 14'h0BB);
    settle();
    checks++; if (grant !== 8'h01 || stall !== 8'h04) begin
      errors++; $display("FAIL rr_c0 got grant=%h stall=%h exp=01/04", grant, stall); end
    advance();
    settle();
    checks++; if (grant !== 8'h04) begin errors++; $display("FAIL rr_c1_grant got=%h exp=04", grant); end
    checks++; if (cmd_valid !== 1'b1 || cmd_bank !== 3'd0 || cmd_type !== CMD_ACT || cmd_addr !== 14'h0AA) begin
      errors++; $display("FAIL rr_c1_bus got v=%0b bank=%0d type=%0d addr=%h exp=1/0/0/0aa",
                         cmd_valid, cmd_bank, cmd_type, cmd_addr); end
    clear_req();
    advance();
  endtask

  task automatic test_trcd();
    do_reset();
    set_bank(3, CMD_ACT, 14'h123);
    settle();
    checks++; if (grant !== 8'h08) begin errors++; $display("FAIL trcd_act got=%h exp=08", grant); end
    advance();
    set_bank(3, CMD_RD, 14'h045);
    for (int k = 1; k <= 3; k++) begin
      settle();
      checks++; if (stall[3] !== 1'b1 || grant !== 8'h00) begin
        errors++; $display("FAIL trcd_wait c%0d got stall3=%0b grant=%h exp=1/00", k, stall[3], grant); end
      advance();
    end
    settle();
    checks++; if (grant !== 8'h08) begin errors++; $display("FAIL trcd_rd got=%h exp=08", grant); end
    advance();
    clear_req();
    settle();
    checks++; if (cmd_valid !== 1'b1 || cmd_type !== CMD_RD || cmd_bank !== 3'd3 || cmd_addr !== 14'h045) begin
      errors++; $display("FAIL trcd_bus got v=%0b type=%0d bank=%0d addr=%h exp=1/1/3/045",
                         cmd_valid, cmd_type, cmd_bank, cmd_addr); end
    advance();
  endtask

  task automatic test_tccd();
    do_reset();
    set_bank(1, CMD_RD, 14'h001);
    set_bank(4, CMD_RD, 14'h004);
    settle();
    checks++; if (grant !== 8'h02) begin errors++; $display("FAIL tccd_c0 got=%h exp=02", grant); end
    advance();
    req[1] = 1'b0;
    settle();
    checks++; if (grant !== 8'h00 || stall !== 8'h10) begin
      errors++; $display("FAIL tccd_c1 got grant=%h stall=%h exp=00/10", grant, stall); end
    advance();
    settle();
    checks++; if (grant !== 8'h10) begin errors++; $display("FAIL tccd_c2 got=%h exp=10", grant); end
    clear_req();
    advance();
  endtask

  task automatic test_trp();
    do_reset();
    set_bank(5, CMD_PRE, 14'h0);
    settle();
    checks++; if (grant !== 8'h20) begin errors++; $display("FAIL trp_pre got=%h exp=20", grant); end
    advance();
    set_bank(5, CMD_ACT, 14'h155);
    set_bank(6, CMD_RD, 14'h066);
    settle();
    checks++; if (grant !== 8'h40 || stall !== 8'h20) begin
      errors++; $display("FAIL trp_c1 got grant=%h stall=%h exp=40/20", grant, stall); end
    advance();
    req[6] = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      settle();
      checks++; if (grant !== 8'h00) begin errors++; $display("FAIL trp_wait c%0d got=%h exp=00", k, grant); end
      advance();
    end
    settle();
    checks++; if (grant !== 8'h20) begin errors++; $display("FAIL trp_act got=%h exp=20", grant); end
    clear_req();
    advance();
  endtask

  task automatic test_read_priority();
    logic [NB-1:0] want;
`ifdef READ_PRIORITY_EN
    want = 8'h04;
`else
    want = 8'h01;
`endif
    do_reset();
    set_bank(0, CMD_WR, 14'h010);
    set_bank(2, CMD_RD, 14'h020);
    settle();
    checks++; if (grant !== want) begin errors++; $display("FAIL read_prio got=%h exp=%h", grant, want); end
    clear_req();
    advance();
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_bank(0, CMD_ACT, 14'h0F0);
    advance();
    rst_n = 1'b0;
    clear_req();
    set_bank(7, CMD_ACT, 14'h777);
    advance();
    rst_n = 1'b1;
    settle();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", cmd_valid); end
    checks++; if (grant !== 8'h80) begin errors++; $display("FAIL midrst_grant got=%h exp=80", grant); end
    advance();
    clear_req();
    set_bank(0, CMD_RD, 14'h00F);
    settle();
    checks++; if (grant !== 8'h01) begin errors++; $display("FAIL midrst_trcd_cleared got=%h exp=01", grant); end
    checks++; if (cmd_valid !== 1'b1 || cmd_bank !== 3'd7 || cmd_addr !== 14'h777) begin
      errors++; $display("FAIL midrst_bus got v=%0b bank=%0d addr=%h exp=1/7/777", cmd_valid, cmd_bank, cmd_addr); end
    clear_req();
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          req[b] = ($urandom_range(0, 2) != 0);
          req_cmd[2*b +: 2] = 2'($urandom_range(0, 3));
          req_addr[b*ADDR_BITS +: ADDR_BITS] = ADDR_BITS'($urandom);
        end
      end
      settle();
      checks++; if (grant !== exp_grant) begin
        errors++; $display("FAIL rand_grant n=%0d got=%h exp=%h", n, grant, exp_grant); end
      checks++; if (stall !== (req & ~exp_grant)) begin
        errors++; $display("FAIL rand_stall n=%0d got=%h exp=%h", n, stall, req & ~exp_grant); end
      checks++; if (cmd_valid !== exp_valid || cmd_type !== exp_type ||
                    cmd_bank !== BA_BITS'(exp_bank) || cmd_addr !== exp_addr) begin
        errors++; $display("FAIL rand_bus n=%0d got v=%0b t=%0d b=%0d a=%h exp v=%0b t=%0d b=%0d a=%h",
                           n, cmd_valid, cmd_type, cmd_bank, cmd_addr, exp_valid, exp_type, exp_bank, exp_addr); end
      advance();
    end
    rst_n = 1'b1;
    clear_req();
  endtask

  initial begin
    cyc = 0; ccd_ok = 0; mptr = 0;
    for (int i = 0; i < NB; i++) begin act_ok[i] = 0; rd_ok[i] = 0; end
    exp_grant = '0; exp_valid = 1'b0; exp_type = '0; exp_bank = 0; exp_addr = '0;
    rst_n = 1'b0;
    req = '0; req_cmd = '0; req_addr = '0;
    #1;
    test_reset();
    test_rr_act();
    test_trcd();
    test_tccd();
    test_trp();
    test_read_priority();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Parameter NUM_BANKS, default 8, is the number of bank FSM requesters.
REQ-002 Parameter T_RCD, default 4, is the minimum cycles from ACT to RD/WR on the same bank.
REQ-003 Parameter T_RP, default 4, is the minimum cycles from PRE to ACT on the same bank.
REQ-004 Parameter T_CCD, default 2, is the minimum cycles between any two column commands (RD/WR), across all banks.
REQ-005 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, is the reset: synchronous, active-low.
REQ-007 Port req, input, NUM_BANKS, marks banks requesting the command bus (bank FSM in a *_CHECK state).
REQ-008 Port req_cmd, input, 2*NUM_BANKS, carries the per-bank command type (bank_cmd_t), slice i belonging to bank i.
REQ-009 Port req_addr, input, ADDR_BITS*NUM_BANKS, carries the per-bank row or column address.
REQ-010 Port stall, output, NUM_BANKS, holds a bank in its CHECK state.
REQ-011 Port grant, output, NUM_BANKS, is a one-hot grant, or all zero.
REQ-012 Ports cmd_valid (1), cmd_type (2), cmd_bank (BA_BITS) and cmd_addr (ADDR_BITS), outputs, form the registered command bus.

Function
REQ-013 A bank i is eligible when req[i]=1 and its timing constraint is met:
- ACT: bank i's tRP counter is 0.
- RD/WR: bank i's tRCD counter is 0 and the global tCCD counter is 0.
- PRE: always eligible.
REQ-014 At most one eligible bank is granted per cycle; grant is combinational from the current req and counters.
REQ-015 Selection among eligible banks is round-robin, starting from the priority pointer; the pointer resets to 0.
REQ-016 After a grant to bank k, the pointer becomes (k+1) mod NUM_BANKS; with no grant, the pointer holds.
REQ-017 stall[i] = req[i] & ~grant[i]; stall[i] is 0 whenever req[i]=0.
REQ-018 The command bus is registered, with one-cycle latency. The cycle after a grant to bank k:
- cmd_valid=1, cmd_bank=k, and cmd_type/cmd_addr equal bank k's request slices sampled at the grant.
- With no grant, cmd_valid=0 and cmd_type, cmd_bank and cmd_addr are 0.
REQ-019 On a granted ACT to bank k, tRCD[k] loads T_RCD-1; on a granted PRE to bank k, tRP[k] loads T_RP-1.
REQ-020 On a granted RD or WR, the tCCD counter loads T_CCD-1.
REQ-021 All counters decrement by 1 per cycle when nonzero and saturate at 0; a load in the same cycle overrides the decrement.
REQ-022 A request whose type is not eligible is not granted and stays stalled while other eligible banks proceed; there is no head-of-line blocking.
REQ-023 A bank's request may change type or drop while stalled; eligibility is re-evaluated every cycle.

Reset
REQ-024 While rst_n=0 at a clock edge, the following clear: all counters, the pointer, cmd_valid, cmd_type, cmd_bank and cmd_addr.
REQ-025 grant and stall are combinational and follow req during reset, but no grant affects state.
REQ-026 Reset asserted mid-operation discards a pending registered command; cmd_valid=0 on the cycle after reset.

Configuration
REQ-027 With READ_PRIORITY_EN defined, any eligible RD beats eligible WR, ACT and PRE regardless of pointer position. Round-robin then applies within the winning class.
REQ-028 Without READ_PRIORITY_EN, pure round-robin over all eligible requests applies, per REQ-015.

Structure
REQ-029 Package usertype holds bank_cmd_t (CMD_ACT=0, CMD_RD=1, CMD_WR=2, CMD_PRE=3) and the default timing constants; ADDR_BITS and BA_BITS come from define.sv.
REQ-030 Sub-module rr_arbiter (NUM_BANKS-wide request vector, pointer input, one-hot grant output, purely combinational) implements the rotation; cmd_arbiter holds the counters, pointer and output registers.

Verification
REQ-031 Scenario: req=8'b0000_0101, both ACT, counters 0, pointer 0.
- Cycle 0: grant=bank 0, stall=8'b0000_0100.
- Cycle 1: grant=bank 2, and cmd_valid=1, cmd_bank=0, cmd_type=ACT.
REQ-032 Scenario: ACT granted to bank 3 at cycle 0, then bank 3 requests RD from cycle 1.
- Cycles 1-3 (default T_RCD=4): stall[3]=1.
- Cycle 4: grant to bank 3.
- Cycle 5: cmd_type=RD.
REQ-033 Scenario: banks 1 and 4 both request RD with tRCD expired.
- Cycle 0: bank 1 granted.
- Cycle 1: bank 4 stalled (T_CCD=2).
- Cycle 2: bank 4 granted.
REQ-034 Scenario: PRE granted to bank 5, then bank 5 requests ACT immediately.
- Grant occurs exactly 4 cycles after the PRE grant.
- A concurrent RD on bank 6 (eligible) is granted in between.
REQ-035 Scenario: READ_PRIORITY_EN, pointer 0, bank 0 WR and bank 2 RD, both eligible.
- Defined: bank 2 is granted.
- Undefined: bank 0 is granted.
REQ-036 Scenario: rst_n=0 for one cycle, applied the cycle after a grant.
- cmd_valid=0 on the next cycle.
- The pointer and all counters are 0.
- A new ACT request from bank 7 is granted on the first cycle after reset.
